fifo_wl: RTL and testbench
==========================

FIFO_WL -- requirements
Module: fifo_wl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, number of entries; SHALL be a power of two and at least 4.
REQ-002 Parameter FIFO_WIDTH, default 32, data word width in bits.
REQ-003 Parameter AFULL_THRESH, default FIFO_DEPTH-2, fill level at or above which almost_full asserts; legal range 1..FIFO_DEPTH.
REQ-004 AW denotes $clog2(FIFO_DEPTH) throughout this document.
REQ-005 w_clk  in  1  write-domain clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset; asynchronous assert, active-high.
REQ-007 wr_en  in  1  write request from the producer.
REQ-008 w_data  in  FIFO_WIDTH  write data from the producer.
REQ-009 clr_ovf  in  1  clears the sticky overflow flag.
REQ-010 rptr2wl  in  AW+1  Gray-coded read pointer from the read domain; arrives unsynchronized.
REQ-011 wptr2rl  out  AW+1  Gray-coded write pointer to the read domain; driven directly by a flop.
REQ-012 w_addr  out  AW  memory write address.
REQ-013 mem_we  out  1  memory write strobe.
REQ-014 mem_wdata  out  FIFO_WIDTH  memory write data.
REQ-015 full  out  1  FIFO full.
REQ-016 almost_full  out  1  fill level is at or above AFULL_THRESH.
REQ-017 w_level  out  AW+1  fill level as seen from the write domain, range 0..FIFO_DEPTH.
REQ-018 overflow  out  1  sticky flag: a write was attempted while the FIFO was full.

Function
REQ-019 The block SHALL hold a binary write pointer wbin and a Gray write pointer wgray, both AW+1 bits and both registered.
REQ-020 A write is accepted when wr_en=1 and full=0; this is combinational from the current-cycle state.
REQ-021 mem_we SHALL equal wr_en AND NOT full, combinationally.
REQ-022 mem_wdata SHALL equal w_data (pass-through).
REQ-023 w_addr SHALL equal wbin[AW-1:0].
REQ-024 On an accepted write, the next edge SHALL load wbin+1 into wbin (modulo 2^(AW+1)) and gray(wbin+1) into wgray, where gray(x) = (x>>1)^x.
REQ-025 wptr2rl SHALL equal wgray; it SHALL never be combinationally derived.
REQ-026 rptr2wl SHALL pass through a 2-flop synchronizer to produce rq2; a change on rptr2wl is visible in full, w_level and almost_full after 2 w_clk edges.
REQ-027 full SHALL equal 1 exactly when wgray equals {~rq2[AW:AW-1], rq2[AW-2:0]}.
REQ-028 w_level SHALL equal (wbin - g2b(rq2)) modulo 2^(AW+1), where g2b is combinational Gray-to-binary conversion.
REQ-029 almost_full SHALL equal (w_level >= AFULL_THRESH).
REQ-030 A write with wr_en=1 while full=1 SHALL be dropped: no pointer change and mem_we=0.
REQ-031 A dropped write SHALL set overflow at the next edge.
REQ-032 clr_ovf=1 SHALL clear overflow at the next edge; if set and clear coincide, set wins.
REQ-033 Wrap-around: w_addr goes from FIFO_DEPTH-1 to 0 with no bubble; wbin wraps from 2^(AW+1)-1 to 0.
REQ-034 full deassertion after a read is pessimistic by the synchronizer latency; full SHALL never deassert early.

Reset
REQ-035 rst=1 SHALL immediately and asynchronously clear wbin, wgray, both synchronizer stages and overflow.
REQ-036 While rst=1 the outputs SHALL be: wptr2rl=0, w_addr=0, full=0, almost_full=0 (given AFULL_THRESH>=1), w_level=0, overflow=0, and mem_we=0 even if wr_en=1.
REQ-037 Reset deassertion SHALL be synchronized externally; the block performs no deassertion synchronization.
REQ-038 An assertion of rst mid-operation SHALL abandon all in-flight state; the read side is reset by the same system reset.

Structure
REQ-039 A shared package fifo_pkg SHALL hold the default depth and width constants and the gray/g2b conversion functions; the read-side controller uses the same functions.
REQ-040 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, parameterized by width, with asynchronous active-high reset to 0.
REQ-041 The memory array is outside this block.

Verification (FIFO_DEPTH=16, AFULL_THRESH=14)
REQ-042 Reset: assert rst with wr_en=1 -> wptr2rl=5'b00000, mem_we=0, full=0, w_level=0, overflow=0.
REQ-043 Fill: hold rptr2wl=0 and write 16 words -> almost_full rises after the 14th write; after the 16th write full=1, w_level=16, wptr2rl=5'b11000.
REQ-044 Overflow: a 17th write while full -> mem_we=0, w_addr stays 0, overflow=1 next edge; clr_ovf with wr_en=0 -> overflow=0; simultaneous set and clear -> overflow=1.
REQ-045 Drain visibility: from full, set rptr2wl=5'b00110 (4) -> full stays 1 for one edge, then full=0 and w_level=12 after the 2nd edge.
REQ-046 Wrap: 40 writes with rptr2wl tracking wptr2rl two cycles behind -> w_addr sequence 15->0 without a stall, wptr2rl 5'b10000->5'b00000, full never asserts.
REQ-047 Mid-operation reset: at w_level=10 assert rst asynchronously, between clock edges -> all outputs reach their REQ-036 values before the next w_clk edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the write and read sides of the async FIFO.
// Helpers work on a wide vector; callers size-cast to their pointer width.
package fifo_pkg;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_WIDTH_DEF = 32;
    localparam int PTR_MAX_W      = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    // Prefix XOR from the MSB down; zero-extended inputs convert correctly.
    function automatic ptr_t g2b(input ptr_t g);
        ptr_t b;
        b = g;
        for (int s = 1; s < PTR_MAX_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction
endpackage

// File: rtl/fifo_wl_if.sv
// Producer-side write handshake and memory write port of the FIFO write-domain controller.
interface fifo_wl_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             wr_en;
    logic [WIDTH-1:0] w_data;
    logic [AW-1:0]    w_addr;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;

    modport master (
        output wr_en, w_data,
        input  w_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_en, w_data,
        output w_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the incoming Gray read pointer.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/fifo_wl.sv
// Write-domain controller of an async FIFO: write pointer, full/level flags, sticky overflow.
module fifo_wl
    import fifo_pkg::*;
#(
    parameter  int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter  int FIFO_WIDTH   = FIFO_WIDTH_DEF,
    parameter  int AFULL_THRESH = FIFO_DEPTH - 2,
    localparam int AW           = $clog2(FIFO_DEPTH),
    localparam int PW           = AW + 1
) (
    input  logic          w_clk,
    input  logic          rst,
    fifo_wl_if.slave      wif,
    input  logic          clr_ovf,
    input  logic [AW:0]   rptr2wl,
    output logic [AW:0]   wptr2rl,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   w_level,
    output logic          overflow
);
    localparam logic [AW:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wgray_q, wgray_d;
    logic        ovf_q, ovf_d;
    logic [AW:0] rq2;
    logic [AW:0] rbin;
    logic        wr_acc;

    sync_2ff #(.WIDTH(PW)) u_rptr_sync (
        .clk (w_clk),
        .rst (rst),
        .d_i (rptr2wl),
        .q_o (rq2)
    );

    assign rbin    = PW'(g2b(ptr_t'(rq2)));
    assign full    = (wgray_q == {~rq2[AW:AW-1], rq2[AW-2:0]});
    assign w_level = wbin_q - rbin;

    // Gated by rst so a held write request cannot strobe memory while in reset.
    assign wr_acc = wif.wr_en & ~full & ~rst;

    always_comb begin
        wbin_d  = wbin_q;
        ovf_d   = ovf_q;
        if (wr_acc) begin
            wbin_d = wbin_q + 1'b1;
        end
        wgray_d = PW'(gray(ptr_t'(wbin_d)));
        if (wif.wr_en && full) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wptr2rl       = wgray_q;
    assign almost_full   = (w_level >= AFULL_LVL);
    assign overflow      = ovf_q;
    assign wif.w_addr    = wbin_q[AW-1:0];
    assign wif.mem_we    = wr_acc;
    assign wif.mem_wdata = wif.w_data;
endmodule

// File: tb/tb_fifo_wl.sv
// Randomized scoreboard bench for fifo_wl (depth 16, almost-full threshold 14).
module tb_fifo_wl;
    localparam int DEPTH = 16;
    localparam int THR   = 14;

    logic       w_clk;
    logic       rst;
    logic       clr_ovf;
    logic [4:0] rptr2wl;
    logic [4:0] wptr2rl;
    logic       full;
    logic       almost_full;
    logic [4:0] w_level;
    logic       overflow;

    fifo_wl_if #(.WIDTH(32), .AW(4)) wif ();

    fifo_wl #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(32), .AFULL_THRESH(THR)) dut (
        .w_clk       (w_clk),
        .rst         (rst),
        .wif         (wif),
        .clr_ovf     (clr_ovf),
        .rptr2wl     (rptr2wl),
        .wptr2rl     (wptr2rl),
        .full        (full),
        .almost_full (almost_full),
        .w_level     (w_level),
        .overflow    (overflow)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: total accepted writes, read count as presented now and as seen by the writer.
    int wr_total = 0;
    int rd_cur   = 0;
    int rd_q1    = 0;
    int rd_q2    = 0;
    bit m_ovf    = 1'b0;
    logic [35:0] exp_q[$];

    function automatic logic [4:0] g5(input int x);
        logic [4:0] b;
        b = x[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory write monitor: every strobe must match the next write the model accepted.
    always @(negedge w_clk) begin
        logic [35:0] e;
        if (wif.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_mem_we", 64'(wif.w_addr), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("mem_addr", 64'(wif.w_addr), 64'(e[35:32]));
                chk("mem_wdata", 64'(wif.mem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic step(input bit wr, input logic [31:0] d, input bit clr, input int rd);
        int lvl;
        bit mfull;
        bit acc;
        rd_cur      = rd;
        wif.wr_en   = wr;
        wif.w_data  = d;
        clr_ovf     = clr;
        rptr2wl     = g5(rd);
        lvl   = wr_total - rd_q2;
        mfull = (lvl == DEPTH);
        acc   = wr && !mfull;
        if (acc) exp_q.push_back({4'(wr_total % DEPTH), d});
        @(negedge w_clk);
        chk("full", 64'(full), 64'(mfull));
        chk("almost_full", 64'(almost_full), 64'(lvl >= THR));
        chk("w_level", 64'(w_level), 64'(lvl));
        chk("wptr2rl", 64'(wptr2rl), 64'(g5(wr_total)));
        chk("w_addr", 64'(wif.w_addr), 64'(wr_total % DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("mem_we", 64'(wif.mem_we), 64'(acc));
        @(posedge w_clk);
        if (acc) wr_total++;
        if (wr && mfull) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        rd_q2 = rd_q1;
        rd_q1 = rd;
        #1;
    endtask

    // Asserts rst with a write request pending, checks outputs before any clock edge, releases.
    task automatic do_reset(input int dly);
        #(dly);
        rst        = 1'b1;
        wif.wr_en  = 1'b1;
        wif.w_data = 32'hDEAD_BEEF;
        rptr2wl    = '0;
        #1;
        chk("rst_wptr2rl", 64'(wptr2rl), 64'd0);
        chk("rst_w_addr", 64'(wif.w_addr), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_w_level", 64'(w_level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_mem_we", 64'(wif.mem_we), 64'd0);
        @(posedge w_clk);
        #1;
        rst       = 1'b0;
        wif.wr_en = 1'b0;
        wr_total = 0; rd_cur = 0; rd_q1 = 0; rd_q2 = 0; m_ovf = 1'b0;
    endtask

    initial begin
        int full_seen;
        int rd_n;
        int avail;
        rst        = 1'b0;
        clr_ovf    = 1'b0;
        wif.wr_en  = 1'b0;
        wif.w_data = '0;
        rptr2wl    = '0;
        do_reset(0);

        // Fill to full with the read pointer parked at 0.
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 0);
        step(1'b0, 32'h0, 1'b0, 0);
        chk("fill_wptr2rl", 64'(wptr2rl), 64'b11000);

        // Overflow: dropped write, clear, then set-and-clear together.
        step(1'b1, 32'h1717_1717, 1'b0, 0);
        step(1'b0, 32'h0, 1'b1, 0);
        step(1'b0, 32'h0, 1'b0, 0);
        step(1'b1, 32'h2222_2222, 1'b1, 0);
        step(1'b0, 32'h0, 1'b0, 0);
        chk("ovf_set_wins", 64'(overflow), 64'd1);

        // Drain visibility through the synchronizer.
        step(1'b0, 32'h0, 1'b1, 4);
        step(1'b0, 32'h0, 1'b0, 4);
        step(1'b0, 32'h0, 1'b0, 4);
        chk("drain_level", 64'(w_level), 64'd12);

        // Wrap: reader trails the writer by two words.
        full_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, $urandom, 1'b0, (wr_total - 2 > rd_cur) ? wr_total - 2 : rd_cur);
            if (full) full_seen++;
        end
        chk("wrap_no_full", 64'(full_seen), 64'd0);

        // Random traffic with bursty reads so full and overflow get exercised.
        for (int i = 0; i < 400; i++) begin
            rd_n  = rd_cur;
            avail = wr_total - rd_cur;
            if ($urandom_range(0, 9) < 3 && avail > 0)
                rd_n = rd_cur + int'($urandom_range(1, (avail < 4) ? avail : 4));
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0, rd_n);
        end

        // Mid-operation reset between clock edges at level 10.
        do_reset(0);
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 0);
        chk("pre_rst_level", 64'(w_level), 64'd10);
        do_reset(3);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 0);
        step(1'b0, 32'h0, 1'b0, 0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
